sixteen_source_rr_scheduler: RTL
================================

Name: sixteen_source_rr_scheduler

Overview:
Round-robin scheduler that shares the 8-bit 16:1 source multiplexer among 16 requesters.
It grants one source at a time and drives the mux selects s0..s3 (s0 = LSB).
It presents a valid/ready stream to the downstream consumer of the mux output, and holds each grant for up to BURST_LEN accepted beats.
It sits beside the 16:1 mux; its select outputs connect directly to the mux select inputs.

Parameters:
BURST_LEN, 4, maximum accepted beats per grant; legal range 1..255; 8-bit beat counter.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
en  input  1  scheduler enable; low = no new grants
req  input  16  request per source; bit k = mux input k (a=0 ... p=15)
out_ready  input  1  downstream accepts current beat
s0  output  1  mux select bit 0
s1  output  1  mux select bit 1
s2  output  1  mux select bit 2
s3  output  1  mux select bit 3
out_valid  output  1  mux output holds a valid beat from the granted source
grant  output  16  one-hot grant; all-zero when idle

Behaviour:
- Reset (async assert, sync release):
  - s0..s3 = 0, out_valid = 0, grant = 0.
  - State = IDLE, beat_cnt = 0.
  - last_idx = 15, so the first search starts at source 0.
- Beat transfer: occurs in any cycle with out_valid && out_ready.
- Selected index idx = {s3,s2,s1,s0}.
- Arbitration (combinational pick, registered result):
  - Search order is last_idx+1, last_idx+2, ... mod 16.
  - The first set req bit wins.
  - The winner is loaded into idx, grant and last_idx on the next clock edge.
- State IDLE:
  - If en && |req, then next edge: SERVE, out_valid = 1, grant = one-hot(winner), selects = winner, beat_cnt = 0.
  - Latency is 1 cycle from the sampled request to out_valid.
  - Otherwise stay in IDLE with out_valid = 0 and grant = 0; selects hold their last value.
- State SERVE:
  - On each transfer, beat_cnt increments.
  - Grant ends at the edge where either condition holds:
    - (a) a transfer occurs with beat_cnt == BURST_LEN-1; or
    - (b) req[idx] == 0. A transfer in that same cycle still counts as delivered.
  - At grant end, if en && any req, re-arbitrate from last_idx+1 with no bubble:
    - out_valid stays 1.
    - The new grant, selects and beat_cnt = 0 take effect on the same edge.
    - The just-served source may win again only if no other source requests.
  - At grant end otherwise: go to IDLE, out_valid = 0, grant = 0.
- Backpressure: while out_valid && !out_ready, s0..s3, grant and beat_cnt are held stable (unless req[idx] drops, per end condition b).
- en low during SERVE: the current burst completes normally; no new grant is issued; then go to IDLE.
- Request changes of non-granted sources during SERVE have no effect until the next arbitration.
- grant is always one-hot or zero. out_valid == |grant at all times.
- Reset mid-burst: outputs return to reset values immediately; the partial burst is discarded; the pointer restarts at source 0.
- BURST_LEN == 1: every transfer ends the grant, giving pure beat-level round robin.

Test Plan:
1. Reset, then release with req = 0 -> out_valid = 0, grant = 0x0000, {s3..s0} = 0 held for 10 cycles.
2. BURST_LEN = 4, en = 1, req = 0x0010, out_ready = 1 -> out_valid rises 1 cycle later with grant = 0x0010 and sel = 4. After 4 transfers the grant ends and immediately re-grants 0x0010 (sole requester). Drop req -> IDLE.
3. req = 0x8001, BURST_LEN = 1, out_ready = 1 -> grants alternate 0x0001, 0x8000, 0x0001, ... with sel 0, 15, 0; out_valid stays high with no bubble.
4. After serving source 15, req = 0x0006 -> grant = 0x0002 (sel = 1), then 0x0004 (sel = 2), verifying wrap-around of the pointer.
5. Granted source 3, out_ready = 0 for 5 cycles -> sel = 3 and beat_cnt held. Then out_ready = 1 -> remaining beats complete; total accepted = BURST_LEN.
6. Mid-burst: req[idx] drop ends the grant at the next edge and moves to the next requester. Separately, reset_n = 0 mid-burst -> outputs zero asynchronously, and the first post-reset grant goes to the lowest requesting index.

Source files
------------

// File: rtl/sixteen_source_rr_scheduler.sv
// Round-robin owner of the 16:1 source mux: picks one requester at a time,
// drives the mux selects and holds the grant for up to BURST_LEN accepted beats.
module sixteen_source_rr_scheduler #(
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] req,
  input  logic        out_ready,
  output logic        s0,
  output logic        s1,
  output logic        s2,
  output logic        s3,
  output logic        out_valid,
  output logic [15:0] grant
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic [3:0]  r_last, w_last_nxt;
  logic [15:0] r_grant, w_grant_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;

  logic [3:0]  w_win;
  logic [3:0]  w_cand;
  logic        w_found;
  logic        w_xfer;
  logic        w_end;

  // Search starts one past the last winner, so the previous owner comes last.
  always_comb begin
    w_win   = r_last;
    w_cand  = r_last;
    w_found = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      w_cand = r_last + i[3:0];
      if (!w_found && req[w_cand]) begin
        w_win   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign w_xfer = (r_state == SERVE) && out_ready;
  assign w_end  = (r_state == SERVE) &&
                  (!req[r_idx] || (w_xfer && (r_cnt == 8'(BURST_LEN - 1))));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (en && w_found) begin
          w_state_nxt = SERVE;
          w_idx_nxt   = w_win;
          w_last_nxt  = w_win;
          w_grant_nxt = 16'b1 << w_win;
          w_cnt_nxt   = 8'd0;
        end
      end
      SERVE: begin
        if (w_end) begin
          // Hand over without a bubble when anyone is still asking.
          w_cnt_nxt = 8'd0;
          if (en && w_found) begin
            w_idx_nxt   = w_win;
            w_last_nxt  = w_win;
            w_grant_nxt = 16'b1 << w_win;
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = 16'd0;
          end
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= 4'd0;
      r_last  <= 4'hF;
      r_grant <= 16'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign s0        = r_idx[0];
  assign s1        = r_idx[1];
  assign s2        = r_idx[2];
  assign s3        = r_idx[3];
  assign out_valid = (r_state == SERVE);
  assign grant     = r_grant;

endmodule
